// File: rtl/sipo_string_matcher_pkg.sv
// Shared types and constants for the SIPO string matcher.
// Optional feature macro (used by the top): SIPO_STRING_MATCHER_MATCH_CNT_EN
package sipo_string_matcher_pkg;

  // Symbol width, fixed by the upstream 4-bit shifter
  localparam int NIB_W = 4;

  typedef enum logic {IDLE, RECV} state_t;

  typedef logic [1:0] bitcnt_t;

  // Reference target string used by benches
  localparam logic [15:0] DEFAULT_PATTERN = 16'h3A5C;

endpackage

// File: rtl/sipo_nibble_rx.sv
// Serial-to-nibble receiver: collects 4 valid bits (MSB first) into a nibble.
// Besides the registered nib/nib_valid it exposes the completing edge (done)
// and the nibble being assembled (nib_nxt) so the caller can register
// results in the same cycle as nib.
module sipo_nibble_rx
  import sipo_string_matcher_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             si,
  input  logic             si_en,
  input  logic             clr,
  output logic [NIB_W-1:0] nib,
  output logic             nib_valid,
  output logic             done,
  output logic [NIB_W-1:0] nib_nxt
);

  state_t            state;
  bitcnt_t           bit_cnt;
  logic [NIB_W-2:0]  sreg;

  // The 4th valid bit completes the nibble unless clr discards it
  assign done    = si_en && !clr && (state == RECV) && (bit_cnt == 2'd3);
  assign nib_nxt = {sreg, si};

  // Bit counter, shift-in register and IDLE/RECV FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sreg      <= '0;
      nib       <= '0;
      nib_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sreg      <= '0;
      nib_valid <= 1'b0;
    end else begin
      nib_valid <= 1'b0;
      if (si_en) begin
        case (state)
          IDLE: begin
            state   <= RECV;
            bit_cnt <= 2'd1;
            sreg    <= {{(NIB_W-2){1'b0}}, si};
          end
          RECV: begin
            if (bit_cnt == 2'd3) begin
              nib       <= nib_nxt;
              nib_valid <= 1'b1;
              bit_cnt   <= '0;
              sreg      <= '0;
              state     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 2'd1;
              sreg    <= {sreg[NIB_W-3:0], si};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sipo_string_matcher.sv
// Reassembles nibbles from the upstream serial stream and flags when the
// last STR_LEN nibbles equal the target pattern (overlapping matches count).
// Optional saturating match counter: define SIPO_STRING_MATCHER_MATCH_CNT_EN.
module sipo_string_matcher
  import sipo_string_matcher_pkg::*;
#(
  parameter int STR_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     si,
  input  logic                     si_en,
  input  logic                     clr,
  input  logic [NIB_W*STR_LEN-1:0] pattern,
  output logic [NIB_W-1:0]         nib,
  output logic                     nib_valid,
  output logic                     match
`ifdef SIPO_STRING_MATCHER_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]         match_cnt
`endif
);

  localparam int HW     = NIB_W * STR_LEN;
  localparam int FILL_W = $clog2(STR_LEN + 1);

  logic              done;
  logic [NIB_W-1:0]  nib_nxt;
  logic [HW-1:0]     history;
  logic [HW-1:0]     hist_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              match_nxt;

  sipo_nibble_rx u_rx (
    .CLK       (CLK),
    .RST       (RST),
    .si        (si),
    .si_en     (si_en),
    .clr       (clr),
    .nib       (nib),
    .nib_valid (nib_valid),
    .done      (done),
    .nib_nxt   (nib_nxt)
  );

  // Sliding window: oldest nibble in the MSBs, newest enters at the LSBs.
  // Shift form keeps STR_LEN=1 legal (no negative slice bounds).
  assign hist_nxt  = (history << NIB_W) | HW'(nib_nxt);
  assign fill_nxt  = (fill == FILL_W'(STR_LEN)) ? fill : fill + FILL_W'(1);
  // Only a fully populated window may match, so zero history never aliases
  // a pattern containing leading zero nibbles
  assign match_nxt = done && (hist_nxt == pattern) && (fill_nxt == FILL_W'(STR_LEN));

  // History window, fill level and registered match pulse
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else begin
      match <= match_nxt;
      if (done) begin
        history <= hist_nxt;
        fill    <= fill_nxt;
      end
    end
  end

`ifdef SIPO_STRING_MATCHER_MATCH_CNT_EN
  // Saturating match counter; clr leaves it alone, only RST clears it
  always_ff @(posedge CLK) begin
    if (RST)
      match_cnt <= '0;
    else if (match_nxt && (match_cnt != {CNT_W{1'b1}}))
      match_cnt <= match_cnt + CNT_W'(1);
  end
`else
  // Counter width is meaningless without the counter; keep it referenced
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/sipo_string_matcher.md
Name: sipo_string_matcher

Overview:
- Downstream consumer of the 4-bit parallel-in/serial-out shift stage.
- Samples the serial bit stream while the upstream stage is shifting and reassembles 4-bit nibbles, MSB first.
- Compares the most recent STR_LEN nibbles against a programmable target string and flags a match, overlapping matches included.
- Its output feeds the string-recognition result/display logic.

Parameters:
- NIB_W, 4, bits per symbol. Fixed at 4 to match the upstream shifter.
- STR_LEN, 4, number of nibbles in the target string (1..8).
- CNT_W, 8, width of the optional match counter.

Ports:
- CLK  in  1  single rising-edge clock, shared with the upstream shifter.
- RST  in  1  synchronous, active-high reset.
- si  in  1  serial data from the upstream shifter's serial output.
- si_en  in  1  bit-valid. Equals the upstream shift-select (high = shifting). si is sampled only when si_en=1.
- clr  in  1  synchronous soft clear of the partial nibble and the history.
- pattern  in  NIB_W*STR_LEN  target string. The oldest nibble is in the MSBs. Must be held stable while matching.
- nib  out  NIB_W  last completed nibble.
- nib_valid  out  1  one-cycle pulse when nib updates.
- match  out  1  one-cycle pulse when the history equals pattern.
- match_cnt  out  CNT_W  saturating match count. Present only with the optional feature.

Behaviour:
- Reset: RST=1 at a rising edge sets nib=0, nib_valid=0, match=0, bit_cnt=0, history=0, fill=0, match_cnt=0, state=IDLE.
- Reset mid-nibble discards any partial bits.
- FSM states:
  - IDLE: bit_cnt=0, no partial bits. si_en=1 goes to RECV with bit_cnt=1.
  - RECV: bit_cnt 1..3. si_en=1 increments bit_cnt. The 4th bit completes the nibble and returns to IDLE.
  - si_en=0 holds the state. Arbitrary gaps between bits are legal.
- Bit order: the first bit sampled is nib[3]; the 4th bit is nib[0]. This matches the upstream order, which emits B[3] first.
- Completion edge (the edge sampling the 4th bit), all registered together:
  - nib <= assembled value.
  - nib_valid <= 1.
  - history shifts left by NIB_W, new nibble in the LSBs.
  - fill <= min(fill+1, STR_LEN).
  - match <= 1 if (next history == pattern) and (next fill == STR_LEN).
- Latency: nib, nib_valid and match are visible in the cycle immediately after the 4th sampling edge.
- nib_valid and match are high for exactly one cycle. Every other cycle they are 0.
- nib holds its value between completions.
- Overlap: the history is a sliding window and is not cleared on a match. Consecutive nibbles can each produce a match.
- clr=1 at an edge:
  - bit_cnt=0, state=IDLE, history=0, fill=0, nib_valid=0, match=0.
  - nib is retained.
  - clr has priority over a simultaneous si_en=1; that bit is discarded.
  - clr does not clear match_cnt.
- RST has priority over clr and si_en.
- A pattern change takes effect at the next completion edge. No retroactive comparison is made.

Optional Feature:
- Macro: SIPO_STRING_MATCHER_MATCH_CNT_EN.
- When defined:
  - match_cnt port exists.
  - Increments by 1 on every edge where match is being set to 1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by RST.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - Constant NIB_W=4.
  - FSM state typedef {IDLE, RECV}.
  - Bit-count typedef (2 bits).
  - Default pattern constant 16'h3A5C, used by benches.
- One natural sub-module, sipo_nibble_rx:
  - Contains the bit counter, shift-in register and FSM.
  - Outputs nib/nib_valid.
  - The top level adds the history window, fill counter, comparator and optional counter.

Test Plan:
- Basic match: RST, pattern=16'h3A5C, shift nibbles 3,A,5,C with si_en=1 continuously. Required:
  - nib_valid pulses 4 times, 4 cycles apart.
  - nib sequence 3,A,5,C.
  - match=1 only in the cycle nib=C.
- Overlap: pattern=16'h1111, send 1,1,1,1,1,1. Required:
  - match pulses on the 4th, 5th and 6th nib_valid.
  - No match on the 1st–3rd.
- Gaps: pattern=16'h3A5C, insert si_en=0 for 3 cycles between bits 2 and 3 of each nibble. Required:
  - Same nib values and a single match on C.
  - nib_valid never asserts during gaps.
- Reset mid-nibble: send 2 bits of 0xF, assert RST for one cycle, then send 3,A,5,C. Required:
  - Outputs all 0 after RST.
  - Partial bits are discarded, so the first nib after reset is 3.
  - match on C.
- Clear priority: after sending 3,A,5, assert clr together with si_en=1 on a bit, then send C. Required:
  - No match.
  - fill=1 after C.
  - nib=C.
  - The bit coincident with clr is ignored.
- Counter (macro defined, CNT_W=2): pattern=16'h1111, send ten 1-nibbles. Required:
  - match pulses 7 times.
  - match_cnt saturates at 3.
